// File: rtl/fetch_queue_stage_pkg.sv
// Shared constants for the fetch front end.
// Holds the default instruction/PC width, the reset PC, the bubble
// instruction, and the encoding of the request FSM states.
package fetch_queue_stage_pkg;

  localparam int                  DEF_WORD_SIZE  = 32;
  localparam logic [31:0]         DEF_PC_INITIAL = 32'h0000_1000;
  localparam logic [31:0]         DEF_NOP        = 32'h0000_0013;

  // IDLE: nothing outstanding
  // WAIT: one request outstanding, its response will be queued
  // KILL: one request outstanding, its response is stale (redirected past it)
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    KILL = 2'd2
  } fetchState_e;

endpackage

// File: rtl/fetch_queue_stage_fifo.sv
// fetch_buffer_fifo: circular FIFO between the cache response and decode.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clear         synchronous clear (wins over push/pop)
//   push/pushData write one entry at the tail
//   pop           drop the head entry
//   headData      current head entry, read straight from storage
//   count         occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap for free.
module fetch_buffer_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  output logic [WIDTH-1:0]           headData,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wrPtr, rdPtr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wrPtr] <= pushData;
  end

  assign headData = mem[rdPtr];

endmodule

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: instruction fetch front end.
// Issues one sequential request at a time to the I-cache, queues returned
// instructions, and feeds the IF/ID register from the queue head.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   redirect_i, redirect_pc_i        execute redirect and its target PC
//   stall_f_i                        block new cache requests
//   stall_d_i, flush_d_i             hold / bubble the decode register
//   ic_req_o, ic_pc_o, ic_ready_i    cache request handshake
//   ic_resp_valid_i, ic_resp_instr_i cache response
//   instr_d_o, pc_d_o, pcplus4_d_o, valid_d_o  decode register
//   q_count_o                        queue occupancy
module fetch_queue_stage
  import fetch_queue_stage_pkg::*;
#(
  parameter int                   WORD_SIZE  = DEF_WORD_SIZE,
  parameter int                   DEPTH      = 4,
  parameter logic [WORD_SIZE-1:0] PC_INITIAL = DEF_PC_INITIAL,
  parameter logic [WORD_SIZE-1:0] NOP        = DEF_NOP
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_i,
  input  logic [WORD_SIZE-1:0]       redirect_pc_i,
  input  logic                       stall_f_i,
  input  logic                       stall_d_i,
  input  logic                       flush_d_i,
  output logic                       ic_req_o,
  output logic [WORD_SIZE-1:0]       ic_pc_o,
  input  logic                       ic_ready_i,
  input  logic                       ic_resp_valid_i,
  input  logic [WORD_SIZE-1:0]       ic_resp_instr_i,
  output logic [WORD_SIZE-1:0]       instr_d_o,
  output logic [WORD_SIZE-1:0]       pc_d_o,
  output logic [WORD_SIZE-1:0]       pcplus4_d_o,
  output logic                       valid_d_o,
  output logic [$clog2(DEPTH+1)-1:0] q_count_o
);

  localparam int             CW      = $clog2(DEPTH+1);
  localparam logic [CW:0]    DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [WORD_SIZE-1:0] FOUR = WORD_SIZE'(4);

  typedef struct packed {
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] instr;
  } qEntry_t;

  fetchState_e          state, stateNext;
  logic [WORD_SIZE-1:0] pcF, reqPc;
  logic [CW-1:0]        qCount;
  logic [CW:0]          occupancy;
  qEntry_t              pushEntry, headEntry;
  logic                 xfer, push, pop;

  // An outstanding WAIT request already owns a queue slot.
  assign occupancy = {1'b0, qCount} + (CW+1)'(state == WAIT);

  // A new request may go out when nothing is outstanding or the outstanding
  // one completes this cycle.
  assign ic_req_o = !rst && (state == IDLE || ic_resp_valid_i) && !stall_f_i
                    && !redirect_i && (occupancy < DEPTH_W);
  assign ic_pc_o  = pcF;
  assign xfer     = ic_req_o && ic_ready_i;

  always_comb begin
    stateNext = state;
    push      = 1'b0;
    pop       = 1'b0;
    if (redirect_i) begin
      // Any in-flight request is now stale; a response this cycle retires it.
      if (state != IDLE) stateNext = ic_resp_valid_i ? IDLE : KILL;
    end else begin
      push = (state == WAIT) && ic_resp_valid_i;
      pop  = !flush_d_i && !stall_d_i && (qCount != '0);
      if (xfer)                                 stateNext = WAIT;
      else if (state != IDLE && ic_resp_valid_i) stateNext = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pcF   <= PC_INITIAL;
      reqPc <= PC_INITIAL;
    end else begin
      state <= stateNext;
      if (redirect_i)  pcF <= redirect_pc_i;
      else if (xfer)   pcF <= pcF + FOUR;
      if (xfer)        reqPc <= pcF;
    end
  end

  assign pushEntry = '{pc: reqPc, instr: ic_resp_instr_i};

  fetch_buffer_fifo #(
    .WIDTH ($bits(qEntry_t)),
    .DEPTH (DEPTH)
  ) uFifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (redirect_i),
    .push     (push),
    .pushData (pushEntry),
    .pop      (pop),
    .headData (headEntry),
    .count    (qCount)
  );

  assign q_count_o = qCount;

  // Decode register: flush > stall > load from head > bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_d_o   <= NOP;
      pc_d_o      <= PC_INITIAL;
      pcplus4_d_o <= PC_INITIAL + FOUR;
      valid_d_o   <= 1'b0;
    end else if (flush_d_i) begin
      instr_d_o <= NOP;
      valid_d_o <= 1'b0;
    end else if (stall_d_i) begin
      valid_d_o <= valid_d_o;
    end else if (pop) begin
      instr_d_o   <= headEntry.instr;
      pc_d_o      <= headEntry.pc;
      pcplus4_d_o <= headEntry.pc + FOUR;
      valid_d_o   <= 1'b1;
    end else begin
      instr_d_o <= NOP;
      valid_d_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Scoreboard bench for fetch_queue_stage: a 1-cycle cache model answers
// requests, the stimulus pushes the expected decode PC sequence, and a
// monitor compares every instruction loaded into the decode register.
module tb_fetch_queue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_f_i, stall_d_i, flush_d_i;
  logic        ic_req_o;
  logic [31:0] ic_pc_o;
  logic        ic_ready_i;
  logic        ic_resp_valid_i;
  logic [31:0] ic_resp_instr_i;
  logic [31:0] instr_d_o, pc_d_o, pcplus4_d_o;
  logic        valid_d_o;
  logic [2:0]  q_count_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] expq[$];
  bit          cacheHold = 1'b0;

  always #5 clk = ~clk;

  fetch_queue_stage dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .stall_f_i       (stall_f_i),
    .stall_d_i       (stall_d_i),
    .flush_d_i       (flush_d_i),
    .ic_req_o        (ic_req_o),
    .ic_pc_o         (ic_pc_o),
    .ic_ready_i      (ic_ready_i),
    .ic_resp_valid_i (ic_resp_valid_i),
    .ic_resp_instr_i (ic_resp_instr_i),
    .instr_d_o       (instr_d_o),
    .pc_d_o          (pc_d_o),
    .pcplus4_d_o     (pcplus4_d_o),
    .valid_d_o       (valid_d_o),
    .q_count_o       (q_count_o)
  );

  function automatic logic [31:0] instrOf(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic pushRun(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) expq.push_back(base + 32'(4 * i));
  endtask

  task automatic nextCyc;
    @(posedge clk);
    #1;
  endtask

  // Returns at #1 into "cycle 0", the first cycle with rst low.
  task automatic doReset;
    nextCyc();
    rst = 1'b1;
    expq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst        = 1'b0;
    ic_ready_i = 1'b1;
  endtask

  task automatic quiesce;
    ic_ready_i = 1'b0;
    stall_f_i  = 1'b0;
    stall_d_i  = 1'b0;
    flush_d_i  = 1'b0;
    redirect_i = 1'b0;
    cacheHold  = 1'b0;
    repeat (4) nextCyc();
  endtask

  // Cache model: one outstanding request, answered the cycle after transfer
  // unless cacheHold delays it. Pending survives reset to model a stale reply.
  initial begin
    logic        pending, fire, nx;
    logic [31:0] pendPc, npc;
    pending         = 1'b0;
    pendPc          = '0;
    ic_resp_valid_i = 1'b0;
    ic_resp_instr_i = '0;
    forever begin
      @(negedge clk);
      fire = ic_resp_valid_i;
      nx   = ic_req_o && ic_ready_i;
      npc  = ic_pc_o;
      @(posedge clk);
      #2;
      if (fire) pending = 1'b0;
      if (nx) begin
        pending = 1'b1;
        pendPc  = npc;
      end
      ic_resp_valid_i = pending && !cacheHold;
      ic_resp_instr_i = ic_resp_valid_i ? instrOf(pendPc) : 32'hDEAD_BEEF;
    end
  end

  // Monitor: every decode load that produced a valid instruction is checked
  // against the head of the expected queue.
  initial begin
    logic        loadPrev;
    logic [31:0] e;
    loadPrev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && valid_d_o && loadPrev) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL decode_unexpected actual_pc=%h expected=none", pc_d_o);
        end else begin
          e = expq.pop_front();
          chk("decode_pc", pc_d_o, e);
          chk("decode_instr", instr_d_o, instrOf(e));
          chk("decode_pcplus4", pcplus4_d_o, e + 32'd4);
        end
      end
      loadPrev = !rst && !stall_d_i && !flush_d_i;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    stall_f_i     = 1'b0;
    stall_d_i     = 1'b0;
    flush_d_i     = 1'b0;
    ic_ready_i    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_instr", instr_d_o, 32'h0000_0013);
    chk("rst_pc", pc_d_o, 32'h0000_1000);
    chk("rst_pc4", pcplus4_d_o, 32'h0000_1004);
    chk("rst_valid", 32'(valid_d_o), 32'd0);
    chk("rst_count", 32'(q_count_o), 32'd0);

    // Streaming: valid from cycle 3, consecutive PCs
    doReset();
    pushRun(32'h1000, 32);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("t1_req", 32'(ic_req_o), 32'd1);
        chk("t1_reqpc", ic_pc_o, 32'h1000);
      end
      chk("t1_valid", 32'(valid_d_o), 32'(c >= 3));
      nextCyc();
    end
    quiesce();

    // Decode stall fills the queue, then drains without gaps
    doReset();
    pushRun(32'h1000, 32);
    for (int c = 0; c < 18; c++) begin
      if (c == 3)  stall_d_i = 1'b1;
      if (c == 11) stall_d_i = 1'b0;
      @(negedge clk);
      if (c >= 4 && c <= 10) begin
        chk("t2_hold_pc", pc_d_o, 32'h1000);
        chk("t2_hold_valid", 32'(valid_d_o), 32'd1);
      end
      if (c >= 6 && c <= 10) begin
        chk("t2_count_full", 32'(q_count_o), 32'd4);
        chk("t2_req_off", 32'(ic_req_o), 32'd0);
      end
      if (c >= 12) chk("t2_drain_valid", 32'(valid_d_o), 32'd1);
      nextCyc();
    end
    quiesce();

    // Redirect while WAIT with no response: stale reply discarded
    doReset();
    for (int c = 0; c < 8; c++) begin
      if (c == 0) cacheHold = 1'b1;
      if (c == 1) begin
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h2000;
        flush_d_i     = 1'b1;
      end
      if (c == 2) begin
        redirect_i = 1'b0;
        flush_d_i  = 1'b0;
        expq.delete();
        pushRun(32'h2000, 32);
      end
      if (c == 3) cacheHold = 1'b0;
      @(negedge clk);
      if (c == 1) chk("t3_req_wait", 32'(ic_req_o), 32'd0);
      if (c == 2) begin
        chk("t3_req_kill", 32'(ic_req_o), 32'd0);
        chk("t3_pcf", ic_pc_o, 32'h2000);
        chk("t3_count", 32'(q_count_o), 32'd0);
      end
      if (c == 3) begin
        chk("t3_req_after", 32'(ic_req_o), 32'd1);
        chk("t3_reqpc", ic_pc_o, 32'h2000);
      end
      if (c == 4) chk("t3_stale_dropped", 32'(q_count_o), 32'd0);
      if (c == 6) chk("t3_dec_pc", pc_d_o, 32'h2000);
      nextCyc();
    end
    quiesce();

    // Redirect in the same cycle as a response
    doReset();
    for (int c = 0; c < 7; c++) begin
      if (c == 1) begin
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h2000;
        flush_d_i     = 1'b1;
      end
      if (c == 2) begin
        redirect_i = 1'b0;
        flush_d_i  = 1'b0;
        expq.delete();
        pushRun(32'h2000, 32);
      end
      @(negedge clk);
      if (c == 1) chk("t4_req_redirect", 32'(ic_req_o), 32'd0);
      if (c == 2) begin
        chk("t4_count", 32'(q_count_o), 32'd0);
        chk("t4_req", 32'(ic_req_o), 32'd1);
        chk("t4_reqpc", ic_pc_o, 32'h2000);
        chk("t4_valid", 32'(valid_d_o), 32'd0);
      end
      if (c == 3) chk("t4_count_next", 32'(q_count_o), 32'd0);
      if (c == 5) chk("t4_dec_pc", pc_d_o, 32'h2000);
      nextCyc();
    end
    quiesce();

    // Flush together with decode stall
    doReset();
    pushRun(32'h1000, 32);
    for (int c = 0; c < 11; c++) begin
      if (c == 5) stall_f_i = 1'b1;
      if (c == 6) begin
        stall_d_i = 1'b1;
        flush_d_i = 1'b1;
      end
      if (c == 7) begin
        stall_f_i = 1'b0;
        stall_d_i = 1'b0;
        flush_d_i = 1'b0;
      end
      @(negedge clk);
      if (c == 5) chk("t5_req_stallf", 32'(ic_req_o), 32'd0);
      if (c == 6) begin
        chk("t5_count_before", 32'(q_count_o), 32'd1);
        chk("t5_pc_before", pc_d_o, 32'h100C);
      end
      if (c == 7) begin
        chk("t5_flush_instr", instr_d_o, 32'h0000_0013);
        chk("t5_flush_valid", 32'(valid_d_o), 32'd0);
        chk("t5_count_after", 32'(q_count_o), 32'd1);
      end
      if (c == 8) chk("t5_resume_pc", pc_d_o, 32'h1010);
      nextCyc();
    end
    quiesce();

    // Reset while WAIT; the late response must be ignored
    doReset();
    pushRun(32'h1000, 32);
    for (int c = 0; c < 5; c++) begin
      if (c == 4) cacheHold = 1'b1;
      @(negedge clk);
      if (c == 4) chk("t6_req_wait", 32'(ic_req_o), 32'd0);
      nextCyc();
    end
    rst = 1'b1;
    expq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    cacheHold = 1'b0;
    pushRun(32'h1000, 32);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("t6_req", 32'(ic_req_o), 32'd1);
        chk("t6_reqpc", ic_pc_o, 32'h1000);
      end
      if (c == 1) chk("t6_stale_ignored", 32'(q_count_o), 32'd0);
      if (c == 3) chk("t6_dec_pc", pc_d_o, 32'h1000);
      nextCyc();
    end
    quiesce();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
